// File: rtl/sonic_scheduler.sv
// sonic_scheduler
// Round-robin measurement controller for N ultrasonic rangefinders that share
// one time base. Exactly one sensor is fired per slot so echoes never overlap.
// The echo pulse of the selected sensor is timed in microseconds and converted
// to centimetres (us / 58). One result is published per slot and a sticky
// per-sensor "near" flag is maintained.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   enable       run the scheduler; sampled in IDLE and at the end of GAP
//   echo[N]      raw asynchronous echo pins, one per sensor
//   trig[N]      registered trigger outputs, at most one bit high
//   res_valid    one-cycle result strobe
//   res_id       sensor index of the result
//   res_cm       distance in cm, 16'hFFFF on timeout
//   res_timeout  result is a timeout
//   near[N]      per-sensor near flag, updated with each result for that sensor
//   busy         high whenever the FSM is not in IDLE
//
// Result interface: valid-only, no backpressure. res_valid is high for exactly
// one cycle; res_id/res_cm/res_timeout are qualified by it and then hold their
// values until the next result. There is no ready: a consumer must take the
// result in the cycle res_valid is high.
//
// The FSM state is kept in the named signal 'state' (type state_t) so
// checkers can bind to it directly.
module sonic_scheduler #(
  parameter int N_SENSOR   = 4,
  parameter int CLK_PER_US = 100,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 25000,
  parameter int GAP_US     = 60000,
  parameter int NEAR_CM    = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [N_SENSOR-1:0] echo,
  output logic [N_SENSOR-1:0] trig,
  output logic                res_valid,
  output logic [2:0]          res_id,
  output logic [15:0]         res_cm,
  output logic                res_timeout,
  output logic [N_SENSOR-1:0] near,
  output logic                busy
);

  localparam int TRIG_CYC = TRIG_US * CLK_PER_US;
  localparam int WAIT_CYC = TIMEOUT_US * CLK_PER_US;
  localparam int GAP_CYC  = GAP_US * CLK_PER_US;
  localparam int MAX_A    = (TRIG_CYC > WAIT_CYC) ? TRIG_CYC : WAIT_CYC;
  localparam int MAX_CYC  = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int CNT_W    = $clog2(MAX_CYC + 1);
  localparam int PRE_W    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int SEL_W    = (N_SENSOR > 1) ? $clog2(N_SENSOR) : 1;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_US - 1);
  localparam logic [19:0]      US_LIMIT  = 20'(TIMEOUT_US);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(N_SENSOR - 1);
  localparam logic [15:0]      NEAR_LIM  = 16'(NEAR_CM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_GAP
  } state_t;

  state_t             state, state_next;
  logic [SEL_W-1:0]   sel, sel_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [PRE_W-1:0]   pre, pre_next;
  logic [19:0]        us_cnt, us_next;

  logic [N_SENSOR-1:0] sync1, sync2;
  logic                echo_prev;
  logic                echo_sel;
  logic                rise, fall;

  logic                pre_wrap;
  logic [19:0]         us_tick;
  logic [19:0]         quot;
  logic [15:0]         cm_dist;
  logic                fire_dist, fire_to;
  logic                near_bit;
  logic [N_SENSOR-1:0] trig_next;

  // Edge detect only on the selected sensor. echo_prev follows the newly
  // selected bit during TRIG, so a level that is already high when
  // WAIT_RISE is entered never looks like a rising edge.
  assign echo_sel = sync2[sel];
  assign rise     = echo_sel & ~echo_prev;
  assign fall     = ~echo_sel & echo_prev;

  // us_tick includes the prescaler wrap of the current cycle, so a pulse of
  // W clocks measures floor(W / CLK_PER_US) microseconds.
  assign pre_wrap = (pre == PRE_LAST);
  assign us_tick  = us_cnt + 20'(pre_wrap);
  assign quot     = us_tick / 20'd58;
  assign cm_dist  = (quot > 20'h0FFFE) ? 16'hFFFE : quot[15:0];
  assign near_bit = fire_dist && (cm_dist < NEAR_LIM);

  assign busy = (state != S_IDLE);

  always_comb begin
    state_next = state;
    sel_next   = sel;
    cnt_next   = cnt + CNT_W'(1);
    pre_next   = pre;
    us_next    = us_cnt;
    fire_dist  = 1'b0;
    fire_to    = 1'b0;
    trig_next  = '0;

    case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (enable) state_next = S_TRIG;
      end

      S_TRIG: begin
        if (cnt == TRIG_LAST) begin
          state_next = S_WAIT_RISE;
          cnt_next   = '0;
        end
      end

      S_WAIT_RISE: begin
        // A rise coinciding with the timeout wins.
        if (rise) begin
          state_next = S_MEASURE;
          pre_next   = '0;
          us_next    = '0;
          cnt_next   = '0;
        end else if (cnt == WAIT_LAST) begin
          fire_to    = 1'b1;
          state_next = S_GAP;
          cnt_next   = '0;
        end
      end

      S_MEASURE: begin
        pre_next = pre_wrap ? '0 : pre + PRE_W'(1);
        us_next  = us_tick;
        // A fall coinciding with the timeout is a distance result.
        if (fall) begin
          fire_dist  = 1'b1;
          state_next = S_GAP;
          cnt_next   = '0;
        end else if (us_tick >= US_LIMIT) begin
          fire_to    = 1'b1;
          state_next = S_GAP;
          cnt_next   = '0;
        end
      end

      S_GAP: begin
        if (cnt == GAP_LAST) begin
          sel_next   = (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
          cnt_next   = '0;
          state_next = enable ? S_TRIG : S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase

    // trig is registered from the next state so it rises on TRIG entry and
    // falls on the same edge that leaves TRIG.
    if (state_next == S_TRIG) trig_next[sel_next] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      sel         <= '0;
      cnt         <= '0;
      pre         <= '0;
      us_cnt      <= '0;
      sync1       <= '0;
      sync2       <= '0;
      echo_prev   <= 1'b0;
      trig        <= '0;
      res_valid   <= 1'b0;
      res_id      <= '0;
      res_cm      <= '0;
      res_timeout <= 1'b0;
      near        <= '0;
    end else begin
      sync1     <= echo;
      sync2     <= sync1;
      echo_prev <= echo_sel;

      state  <= state_next;
      sel    <= sel_next;
      cnt    <= cnt_next;
      pre    <= pre_next;
      us_cnt <= us_next;
      trig   <= trig_next;

      res_valid <= fire_dist | fire_to;
      if (fire_dist | fire_to) begin
        res_id      <= 3'(sel);
        res_cm      <= fire_dist ? cm_dist : 16'hFFFF;
        res_timeout <= fire_to;
        near[sel]   <= near_bit;
      end
    end
  end

endmodule

// File: tb/tb_sonic_scheduler.sv
`timescale 1ns/1ps
// Bench for sonic_scheduler. Time base is scaled down (CLK_PER_US=2) so the
// whole run stays well under 100k cycles; TRIG/TIMEOUT/GAP in us as planned.
module tb_sonic_scheduler;
  localparam int N          = 4;
  localparam int CLK        = 2;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 2000;
  localparam int GAP_US     = 100;
  localparam int NEAR_CM    = 20;
  localparam int TRIG_CYC   = TRIG_US * CLK;
  localparam int TO_CYC     = TIMEOUT_US * CLK;
  localparam int GAP_CYC    = GAP_US * CLK;

  logic         clk, rst, enable;
  logic [N-1:0] echo, trig, near;
  logic         res_valid, res_timeout, busy;
  logic [2:0]   res_id;
  logic [15:0]  res_cm;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  // Reference model state
  int           msel;
  logic [N-1:0] mnear;
  logic [19:0]  exp_q[$];   // {id, timeout, cm}

  // Last slot observation
  int           r_ok, r_trig_len, r_lat;
  logic [N-1:0] r_first_trig, r_near;
  logic [2:0]   r_id;
  logic [15:0]  r_cm;
  logic         r_to;

  sonic_scheduler #(
    .N_SENSOR(N), .CLK_PER_US(CLK), .TRIG_US(TRIG_US),
    .TIMEOUT_US(TIMEOUT_US), .GAP_US(GAP_US), .NEAR_CM(NEAR_CM)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trig(trig),
    .res_valid(res_valid), .res_id(res_id), .res_cm(res_cm),
    .res_timeout(res_timeout), .near(near), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (!$onehot0(trig)) overlap++;

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Pin pulse of w clocks -> floor(w/CLK) us -> /58 cm. Pulses longer than
  // the timeout window, or no edge at all, give a timeout.
  function automatic logic [16:0] predict(input int mode, input int w);
    logic [16:0] p;
    if (mode != 0 || w > TO_CYC) p = {1'b1, 16'hFFFF};
    else p = {1'b0, 16'((w / CLK) / 58)};
    return p;
  endfunction

  task automatic commit(input int s, input logic [16:0] p);
    mnear[s] = !p[16] && (p[15:0] < 16'(NEAR_CM));
    msel = (msel + 1) % N;
  endtask

  // ---------------- driver ----------------
  // mode 0: pulse of w clocks d clocks after trig falls; 1: pin low;
  // 2: pin left as the caller set it. drop_e: clock (after trig) to drop enable.
  task automatic run_slot(input int s, input int mode, input int d, input int w,
                          input int drop_e);
    int n;
    int e;
    bit got;
    r_ok = 0; r_trig_len = 0; r_lat = -1; r_first_trig = '0;
    n = 0;
    while (trig == '0 && n < 3 * GAP_CYC + 100) begin @(negedge clk); n++; end
    r_first_trig = trig;
    if (!trig[s]) return;
    n = 0;
    while (trig[s] && n < 10 * TRIG_CYC) begin n++; @(negedge clk); end
    r_trig_len = n;
    e = 0; got = 0;
    while (!got && e < 3 * TO_CYC) begin
      if (mode == 0) echo[s] = (e >= d && e < d + w);
      if (e == drop_e) enable = 1'b0;
      if (res_valid) begin
        got = 1; r_lat = e; r_id = res_id; r_cm = res_cm;
        r_to = res_timeout; r_near = near;
      end else begin
        @(negedge clk); e++;
      end
    end
    echo[s] = 1'b0;
    r_ok = got;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; echo = '0;
    msel = 0; mnear = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (trig !== '0) begin errors++; $display("FAIL reset_trig got %b want 0", trig); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", res_valid); end
    checks++; if ({res_id, res_cm, res_timeout} !== '0) begin errors++;
      $display("FAIL reset_res got id=%0d cm=%0h to=%b want 0", res_id, res_cm, res_timeout); end
    checks++; if (near !== '0) begin errors++; $display("FAIL reset_near got %b want 0", near); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single_slot();
    logic [16:0] p;
    p = predict(0, 1160 * CLK);
    enable = 1'b1;
    run_slot(0, 0, 50 * CLK, 1160 * CLK, -1);
    commit(0, p);
    checks++; if (r_first_trig !== 4'b0001) begin errors++; $display("FAIL single_first_trig got %b want 0001", r_first_trig); end
    checks++; if (r_trig_len !== TRIG_CYC) begin errors++; $display("FAIL single_trig_len got %0d want %0d", r_trig_len, TRIG_CYC); end
    checks++; if (r_ok !== 1) begin errors++; $display("FAIL single_result got none want one"); end
    checks++; if ({r_id, r_to, r_cm} !== {3'd0, 1'b0, 16'd20}) begin errors++;
      $display("FAIL single_res got id=%0d to=%b cm=%0d want id=0 to=0 cm=20", r_id, r_to, r_cm); end
    checks++; if (r_near !== mnear) begin errors++; $display("FAIL single_near got %b want %b", r_near, mnear); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b want 0", res_valid); end
    checks++; if (res_cm !== 16'd20) begin errors++; $display("FAIL single_hold_cm got %0d want 20", res_cm); end
  endtask

  task automatic test_near();
    logic [16:0] p;
    p = predict(0, 580 * CLK);
    run_slot(1, 0, 40, 580 * CLK, -1);
    commit(1, p);
    checks++; if (r_first_trig !== 4'b0010) begin errors++; $display("FAIL near_first_trig got %b want 0010", r_first_trig); end
    checks++; if ({r_id, r_to, r_cm} !== {3'd1, 1'b0, 16'd10}) begin errors++;
      $display("FAIL near_res got id=%0d to=%b cm=%0d want id=1 to=0 cm=10", r_id, r_to, r_cm); end
    checks++; if (r_near !== 4'b0010) begin errors++; $display("FAIL near_flag got %b want 0010", r_near); end
  endtask

  task automatic test_no_echo();
    run_slot(2, 1, 0, 0, -1);
    commit(2, predict(1, 0));
    checks++; if (r_lat !== TO_CYC) begin errors++; $display("FAIL no_echo_latency got %0d want %0d", r_lat, TO_CYC); end
    checks++; if ({r_id, r_to, r_cm} !== {3'd2, 1'b1, 16'hFFFF}) begin errors++;
      $display("FAIL no_echo_res got id=%0d to=%b cm=%0h want id=2 to=1 cm=ffff", r_id, r_to, r_cm); end
    checks++; if (r_near !== mnear) begin errors++; $display("FAIL no_echo_near got %b want %b", r_near, mnear); end
  endtask

  task automatic test_stuck();
    echo[3] = 1'b1;   // high before its trigger: no edge, no MEASURE
    run_slot(3, 2, 0, 0, -1);
    commit(3, predict(2, 0));
    checks++; if (r_lat !== TO_CYC) begin errors++; $display("FAIL stuck_latency got %0d want %0d", r_lat, TO_CYC); end
    checks++; if ({r_id, r_to, r_cm} !== {3'd3, 1'b1, 16'hFFFF}) begin errors++;
      $display("FAIL stuck_res got id=%0d to=%b cm=%0h want id=3 to=1 cm=ffff", r_id, r_to, r_cm); end
    // Real rise, then held past the timeout: ends from MEASURE, 3 clk sync delay.
    run_slot(0, 0, 50, TO_CYC + 1000, -1);
    commit(0, predict(0, TO_CYC + 1000));
    checks++; if (r_lat !== 50 + 3 + TO_CYC) begin errors++; $display("FAIL long_latency got %0d want %0d", r_lat, 53 + TO_CYC); end
    checks++; if ({r_id, r_to, r_cm} !== {3'd0, 1'b1, 16'hFFFF}) begin errors++;
      $display("FAIL long_res got id=%0d to=%b cm=%0h want id=0 to=1 cm=ffff", r_id, r_to, r_cm); end
  endtask

  task automatic test_near_clear();
    run_slot(1, 0, 60, 1160 * CLK, -1);
    commit(1, predict(0, 1160 * CLK));
    checks++; if (r_near !== 4'b0000) begin errors++; $display("FAIL near_clear got %b want 0000", r_near); end
  endtask

  task automatic test_boundary();
    // Fall in the same cycle as the us limit: distance wins.
    run_slot(2, 0, 30, TO_CYC, -1);
    commit(2, predict(0, TO_CYC));
    checks++; if ({r_id, r_to, r_cm} !== {3'd2, 1'b0, 16'd34}) begin errors++;
      $display("FAIL bound_fall_at_limit got id=%0d to=%b cm=%0d want id=2 to=0 cm=34", r_id, r_to, r_cm); end
    run_slot(3, 0, 30, TO_CYC + 1, -1);
    commit(3, predict(0, TO_CYC + 1));
    checks++; if ({r_id, r_to, r_cm} !== {3'd3, 1'b1, 16'hFFFF}) begin errors++;
      $display("FAIL bound_past_limit got id=%0d to=%b cm=%0h want id=3 to=1 cm=ffff", r_id, r_to, r_cm); end
    // 1159 us -> 19 cm, just under the near threshold.
    run_slot(0, 0, 30, 1159 * CLK, -1);
    commit(0, predict(0, 1159 * CLK));
    checks++; if ({r_to, r_cm, r_near} !== {1'b0, 16'd19, mnear}) begin errors++;
      $display("FAIL bound_near19 got to=%b cm=%0d near=%b want to=0 cm=19 near=%b", r_to, r_cm, r_near, mnear); end
  endtask

  task automatic test_random_round_robin();
    logic [16:0] p;
    logic [19:0] exp;
    int s, d, w;
    for (int i = 0; i < 6; i++) begin
      s = msel;
      d = int'($urandom_range(5, 300));
      w = int'($urandom_range(100, TO_CYC + 400));
      p = predict(0, w);
      exp_q.push_back({3'(s), p});
      run_slot(s, 0, d, w, -1);
      commit(s, p);
      exp = exp_q.pop_front();
      checks++; if (r_trig_len !== TRIG_CYC || r_first_trig !== 4'(1 << s)) begin errors++;
        $display("FAIL rand_trig[%0d] got %b len %0d want %b len %0d", i, r_first_trig, r_trig_len, 4'(1 << s), TRIG_CYC); end
      checks++; if (r_ok !== 1 || {r_id, r_to, r_cm} !== exp) begin errors++;
        $display("FAIL rand_res[%0d] w=%0d got id=%0d to=%b cm=%0d want id=%0d to=%b cm=%0d",
                 i, w, r_id, r_to, r_cm, exp[19:17], exp[16], exp[15:0]); end
      checks++; if (r_near !== mnear) begin errors++; $display("FAIL rand_near[%0d] got %b want %b", i, r_near, mnear); end
    end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL trig_onehot got %0d overlaps want 0", overlap); end
  endtask

  task automatic test_enable_drop();
    int n, bad;
    while (msel != 1) begin
      run_slot(msel, 0, 20, 200, -1);
      checks++; if (r_ok !== 1) begin errors++; $display("FAIL en_fill_slot got none want result"); end
      commit(msel, predict(0, 200));
    end
    run_slot(1, 0, 40, 600, 40 + 10);   // enable drops during MEASURE
    commit(1, predict(0, 600));
    checks++; if ({r_id, r_to, r_cm} !== {3'd1, 1'b0, 16'((600 / CLK) / 58)}) begin errors++;
      $display("FAIL en_slot_completes got id=%0d to=%b cm=%0d want id=1 to=0 cm=%0d", r_id, r_to, r_cm, (600 / CLK) / 58); end
    n = 0;
    while (busy && n < 10 * GAP_CYC) begin @(negedge clk); n++; end
    checks++; if (n !== GAP_CYC) begin errors++; $display("FAIL en_busy_fall got %0d want %0d", n, GAP_CYC); end
    bad = 0;
    repeat (30) begin @(negedge clk); if (busy || trig != '0) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL en_idle_quiet got %0d busy cycles want 0", bad); end
    enable = 1'b1;
    run_slot(2, 0, 50, 580 * CLK, -1);
    commit(2, predict(0, 580 * CLK));
    checks++; if (r_first_trig !== 4'b0100) begin errors++; $display("FAIL en_resume_sel got %b want 0100", r_first_trig); end
    checks++; if (r_near !== mnear) begin errors++; $display("FAIL en_resume_near got %b want %b", r_near, mnear); end
  endtask

  task automatic test_reset_mid_trig();
    int n;
    run_slot(3, 0, 50, 400, -1);
    commit(3, predict(0, 400));
    n = 0;
    while (!trig[0] && n < 3 * GAP_CYC) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    checks++; if (trig !== 4'b0001 || near !== mnear) begin errors++;
      $display("FAIL rst_pre got trig=%b near=%b want trig=0001 near=%b", trig, near, mnear); end
    #2 rst = 1'b1;
    #1;
    checks++; if (trig !== '0) begin errors++; $display("FAIL rst_async_trig got %b want 0", trig); end
    checks++; if (near !== '0 || busy !== 1'b0) begin errors++;
      $display("FAIL rst_async_state got near=%b busy=%b want 0 0", near, busy); end
    @(negedge clk);
    rst = 1'b0;
    mnear = '0; msel = 0;
    run_slot(0, 0, 60, 580 * CLK, -1);
    commit(0, predict(0, 580 * CLK));
    checks++; if (r_first_trig !== 4'b0001) begin errors++; $display("FAIL rst_restart_sel got %b want 0001", r_first_trig); end
    checks++; if ({r_id, r_to, r_cm} !== {3'd0, 1'b0, 16'd10}) begin errors++;
      $display("FAIL rst_restart_res got id=%0d to=%b cm=%0d want id=0 to=0 cm=10", r_id, r_to, r_cm); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_slot();
    test_near();
    test_no_echo();
    test_stuck();
    test_near_clear();
    test_boundary();
    test_random_round_robin();
    test_enable_drop();
    test_reset_mid_trig();
    enable = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sonic_scheduler.md
Name: sonic_scheduler

Overview:
Round-robin measurement controller for N ultrasonic rangefinders sharing one time base. It fires one sensor at a time so echoes cannot cross-talk, times that sensor's echo pulse in microseconds, and converts the pulse width to centimetres. It publishes one result per slot and keeps a per-sensor "near" flag. It sits between the sensor pins and the motion/obstacle logic, replacing per-sensor free-running trigger/counter pairs.

Parameters:
N_SENSOR, 4, number of sensors (2..8); sensor index width is 3 bits.
CLK_PER_US, 100, clk cycles per microsecond (100 MHz clk).
TRIG_US, 10, trigger pulse width in us.
TIMEOUT_US, 25000, max us from WAIT_RISE entry, and max echo width, before the slot is declared a timeout.
GAP_US, 60000, quiet time after each slot before the next trigger.
NEAR_CM, 20, a distance strictly below this sets the near flag.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  run scheduler; sampled in IDLE and at end of GAP
echo  in  N_SENSOR  raw asynchronous echo inputs, one per sensor
trig  out  N_SENSOR  trigger outputs, at most one bit high at any time
res_valid  out  1  one-cycle pulse: result fields valid
res_id  out  3  sensor index of the result
res_cm  out  16  distance in cm; 16'hFFFF on timeout
res_timeout  out  1  result is a timeout
near  out  N_SENSOR  per-sensor sticky near flag, updated per result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, sel=0, all counters 0, and every output 0 (trig, res_valid, res_id, res_cm, res_timeout, near, busy). Sync flops are also cleared. Reset mid-slot aborts immediately and trig drops asynchronously.
- Echo path: 2-FF synchronizer per bit, then a third register on the selected bit only for edge detect. A rise or fall is seen 3 clk after the pin changes. Echo on non-selected sensors is ignored.
- States:
  - IDLE: if enable, go to TRIG. sel is unchanged.
  - TRIG: trig[sel]=1 (registered) for exactly TRIG_US*CLK_PER_US cycles, then WAIT_RISE.
  - WAIT_RISE: wait for a rising edge on the synced echo[sel]. A level already high on entry does not count; only a 0->1 edge does. On the edge, clear us_cnt and the prescaler, then go to MEASURE. If TIMEOUT_US*CLK_PER_US cycles elapse first, emit a timeout result and go to GAP.
  - MEASURE: the prescaler counts 0..CLK_PER_US-1; each wrap increments us_cnt (20 bits). On a falling edge, emit a distance result and go to GAP. If us_cnt reaches TIMEOUT_US, emit a timeout result and go to GAP.
  - GAP: hold GAP_US*CLK_PER_US cycles. Then sel advances to (sel+1) mod N_SENSOR. Go to TRIG if enable, else IDLE.
- Enable: deasserting enable mid-slot never truncates a slot; the current slot completes through GAP.
- Result: res_valid is high for exactly 1 cycle, the cycle after the terminating event (edge or timeout). res_id=sel.
  - Distance result: res_cm = floor(us_cnt/58), saturated to 16'hFFFE; res_timeout=0.
  - Timeout result: res_cm=16'hFFFF; res_timeout=1.
  - res_id, res_cm and res_timeout hold their values until the next result.
- near[res_id] updates in the same cycle as res_valid: set to 1 iff !res_timeout && res_cm < NEAR_CM, else 0. Other near bits are untouched.
- Division may be combinational or iterative, but res_valid timing above is fixed. An iterative divider must finish inside the GAP start and delay res_valid only if GAP_US*CLK_PER_US < divider cycles; that case is illegal for legal parameters.
- Simultaneous events: a fall and a timeout in the same cycle count as a distance result. A rise and a timeout in the same cycle count as a rise.
- busy=1 from TRIG entry until return to IDLE.

Test Plan:
Bench overrides: CLK_PER_US=10, TRIG_US=10, TIMEOUT_US=2000, GAP_US=100, N_SENSOR=4.
- Single slot: enable=1; echo[0] rises 50 us after trig falls and is high 1160 us -> trig[0] high exactly 100 cycles; res_valid pulse with id=0, cm=20, near[0]=0. Next trig is trig[1].
- Near: echo[1] high 580 us -> res_cm=10, near[1]=1. A later 1160 us echo on sensor 1 clears near[1].
- No echo: sensor 2 pin held low -> timeout 20000 cycles after WAIT_RISE entry; res_cm=FFFF, res_timeout=1, near[2]=0.
- Stuck echo: echo[3] held high before its trigger -> no MEASURE entry (no edge); timeout result with id=3. Echo held high >2000 us after a real rise -> timeout from MEASURE.
- Round-robin and enable: run 6 slots -> ids 0,1,2,3,0,1 and never two trig bits high. Drop enable during MEASURE of slot 1 -> slot completes, busy falls after GAP, next enable starts at sel=2.
- Reset mid-TRIG: assert rst asynchronously while trig[0]=1 -> trig=0 and near=0 without a clk edge; after release, the scheduler restarts at sel=0.
